// File: rtl/aes128_enc_iter_if.sv
`timescale 1ns/1ps
// Block-in / ciphertext-out handshake bundle for the iterative AES-128 engine.
// The engine takes the slave view; the block source and sink take the master view.
interface aes128_enc_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;
  logic         busy;

  modport master (
    output in_valid, din, key, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din, key, out_ready,
    output in_ready, out_valid, dout, busy
  );
endinterface

// File: rtl/aes128_enc_iter.sv
`timescale 1ns/1ps
// Iterative AES-128 encryptor: ROUNDS_PER_CYCLE cipher rounds per active clock,
// round keys expanded on the fly, valid/ready handshakes on input and output.
module aes128_enc_iter #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit OUT_CLEAR        = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  input logic              clk_en,
  aes128_enc_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] STEP     = 4'(ROUNDS_PER_CYCLE);
  localparam logic [3:0] LAST_RND = 4'(11 - ROUNDS_PER_CYCLE);

  localparam logic [2047:0] S_BOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return S_BOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Rcon follows the round number directly; rounds outside 1..10 never reach a register.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h0};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // SubBytes and ShiftRows fused: output (row r, col c) reads input (row r, col c+r).
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
    if (!last)
      for (int c = 0; c < 4; c++)
        t[127 - 32 * c -: 32] = mix_column(t[127 - 32 * c -: 32]);
    return t ^ rk;
  endfunction

  state_t       state_q, state_d;
  logic [127:0] st_p1, rk_p1, dout_p2;
  logic [3:0]   rnd_p1;
  logic         accept, last_step;

  // Round cascade: stage g computes round rnd_p1+g from the previous stage's outputs
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
    logic [127:0] st_i, rk_i, st_o, rk_o;
    logic [3:0]   r;
    if (g == 0) begin : g_first
      assign st_i = st_p1;
      assign rk_i = rk_p1;
    end else begin : g_next
      assign st_i = g_rnd[g-1].st_o;
      assign rk_i = g_rnd[g-1].rk_o;
    end
    assign r    = rnd_p1 + 4'(g);
    assign rk_o = key_expand(rk_i, rcon(r));
    assign st_o = aes_round(st_i, rk_o, r == 4'd10);
  end

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign last_step = (state_q == RUN) && (rnd_p1 == LAST_RND);

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: cipher state, round key and round counter; stage p2: captured ciphertext
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_p1   <= '0;
      rk_p1   <= '0;
      rnd_p1  <= '0;
      dout_p2 <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      if (accept) begin
        st_p1  <= bus.din ^ bus.key;
        rk_p1  <= bus.key;
        rnd_p1 <= 4'd1;
      end else if (state_q == RUN) begin
        st_p1  <= g_rnd[ROUNDS_PER_CYCLE-1].st_o;
        rk_p1  <= g_rnd[ROUNDS_PER_CYCLE-1].rk_o;
        rnd_p1 <= rnd_p1 + STEP;
        if (last_step) dout_p2 <= g_rnd[ROUNDS_PER_CYCLE-1].st_o;
      end
    end
  end

  assign bus.dout = (OUT_CLEAR && state_q != DONE) ? '0 : dout_p2;
endmodule

// File: tb/tb_aes128_enc_iter.sv
`timescale 1ns/1ps
// Bench for aes128_enc_iter: four engines (1, 2, 5, 10 rounds/cycle) share one stimulus
// stream; each has a scoreboard fed at accept and drained at the output handshake.
module tb_aes128_enc_iter;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         clk_en;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] din;
  logic [127:0] key;
  logic         stream_chk;
  int           act_cnt;
  int           n_run;
  int           n_fail;
  logic [7:0]   sb [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && clk_en) act_cnt <= act_cnt + 1;

  task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference cipher: full 44-word key schedule up front, state as a 4x4 byte matrix.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127 - 8 * (4 * c + r) -: 8] ^ w[c][31 - 8 * r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
          s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++) s[r][c] ^= w[4 * rnd + c][31 - 8 * r -: 8];
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8 * (4 * c + r) -: 8] = s[r][c];
    return res;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int R  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    localparam bit OC = (g != 1);
    localparam int N  = 10 / R;

    aes128_enc_iter_if ifc ();
    assign ifc.in_valid  = in_valid;
    assign ifc.din       = din;
    assign ifc.key       = key;
    assign ifc.out_ready = out_ready;

    aes128_enc_iter #(.ROUNDS_PER_CYCLE(R), .OUT_CLEAR(OC)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .bus    (ifc.slave)
    );

    exp_t         q [$];
    exp_t         e;
    logic         ov_prev   = 1'b0;
    logic [127:0] last_dout = '0;
    int           last_acc  = -1;

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        ov_prev  = 1'b0;
        last_acc = -1;
        check($sformatf("reset_outputs_r%0d", R),
              {ifc.in_ready, ifc.out_valid, ifc.busy, ifc.dout}, {1'b1, 1'b0, 1'b0, 128'h0});
      end else begin
        if (ifc.out_valid && !ov_prev) begin
          if (q.size() == 0) check($sformatf("unexpected_out_r%0d", R), q.size(), 1);
          else check($sformatf("latency_r%0d", R), act_cnt - q[0].acc, N);
        end
        if (!ifc.out_valid && ov_prev)
          check($sformatf("dout_idle_r%0d", R), ifc.dout, OC ? 128'h0 : last_dout);
        if (clk_en && ifc.out_valid && out_ready) begin
          if (q.size() == 0) begin
            check($sformatf("unexpected_hs_r%0d", R), q.size(), 1);
          end else begin
            e = q.pop_front();
            check($sformatf("ct_r%0d", R), ifc.dout, e.ct);
          end
          last_dout = ifc.dout;
        end
        if (clk_en && ifc.in_ready && in_valid) begin
          if (stream_chk && last_acc >= 0)
            check($sformatf("spacing_r%0d", R), act_cnt + 1 - last_acc, N + 2);
          last_acc = stream_chk ? act_cnt + 1 : -1;
          e.ct  = aes_ref(din, key);
          e.acc = act_cnt + 1;
          q.push_back(e);
        end
        ov_prev = ifc.out_valid;
      end
    end
  end

  function automatic int pending();
    return g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size() + g_dut[3].q.size();
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] p, input logic [127:0] k);
    logic acc;
    acc      = 1'b0;
    din      = p;
    key      = k;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = clk_en && g_dut[0].ifc.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", g_dut[0].ifc.in_ready, 1);
  endtask

  task automatic wait_done0();
    int n;
    n = 0;
    while (!g_dut[0].ifc.out_valid && n < 100) begin
      cycle();
      n++;
    end
    if (!g_dut[0].ifc.out_valid) check("done_timeout", g_dut[0].ifc.out_valid, 1);
  endtask

  task automatic pulse_out();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic check_douts(input string tag, input logic [127:0] exp);
    check({tag, "_r1"},  {g_dut[0].ifc.out_valid, g_dut[0].ifc.dout}, {1'b1, exp});
    check({tag, "_r2"},  {g_dut[1].ifc.out_valid, g_dut[1].ifc.dout}, {1'b1, exp});
    check({tag, "_r5"},  {g_dut[2].ifc.out_valid, g_dut[2].ifc.dout}, {1'b1, exp});
    check({tag, "_r10"}, {g_dut[3].ifc.out_valid, g_dut[3].ifc.dout}, {1'b1, exp});
  endtask

  task automatic run_kat(input logic [127:0] p, input logic [127:0] k, input logic [127:0] ct,
                         input string tag);
    out_ready = 1'b0;
    send(p, k);
    in_valid = 1'b0;
    wait_done0();
    check_douts(tag, ct);
    pulse_out();
  endtask

  initial begin
    logic [7:0] inv;
    int         n;
    n_run = 0;
    n_fail = 0;
    act_cnt = 0;
    stream_chk = 1'b0;
    rst_n = 1'b0;
    clk_en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    din = '0;
    key = '0;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
              {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    repeat (3) cycle();
    #2 rst_n = 1'b1;
    cycle();

    run_kat(C1_PT, C1_KEY, C1_CT, "kat_c1");
    run_kat(B_PT, B_KEY, B_CT, "kat_b");

    // Backpressure: result held while a second block knocks on the input
    out_ready = 1'b0;
    send(C1_PT, C1_KEY);
    in_valid = 1'b0;
    wait_done0();
    din = B_PT;
    key = B_KEY;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      @(negedge clk);
      check("bp_hold", {g_dut[0].ifc.in_ready, g_dut[0].ifc.out_valid, g_dut[0].ifc.dout},
            {1'b0, 1'b1, C1_CT});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(B_PT, B_KEY);
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_done0();
    check_douts("bp_second", B_CT);
    pulse_out();

    // Clock enable toggling every clock during RUN
    send(C1_PT, C1_KEY);
    in_valid = 1'b0;
    clk_en = 1'b0;
    n = 0;
    do begin
      cycle();
      clk_en = ~clk_en;
      n++;
    end while (!g_dut[0].ifc.out_valid && n < 100);
    check("clken_clocks", n, 20);
    clk_en = 1'b1;
    check("clken_ct", g_dut[0].ifc.dout, C1_CT);
    pulse_out();

    // Asynchronous reset in the middle of a block
    send(C1_PT, C1_KEY);
    in_valid = 1'b0;
    repeat (4) cycle();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid", {g_dut[0].ifc.in_ready, g_dut[0].ifc.out_valid, g_dut[0].ifc.dout},
          {1'b1, 1'b0, 128'h0});
    cycle();
    cycle();
    #2 rst_n = 1'b1;
    cycle();
    run_kat(C1_PT, C1_KEY, C1_CT, "kat_after_rst");

    // Back-to-back streaming
    out_ready = 1'b1;
    stream_chk = 1'b1;
    for (int i = 0; i < 100; i++)
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    stream_chk = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 100 && pending() != 0; i++) cycle();
    check("drain", pending(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected summary before timeout");
    $fatal(1, "watchdog timeout");
  end
endmodule
